// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Redirect, stall and flush from later stages steer this stage.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic [15:0] fetch_count
);

  logic [15:0] pc;
  logic [15:0] pc_plus1;

  assign imem_addr = pc;
  assign pc_plus1  = pc + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else if (redirect_valid) begin
      pc            <= redirect_target;
      ifid_instr    <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (stall) begin
      // PC holds; a concurrent flush still bubbles IF/ID
      if (flush) begin
        ifid_instr    <= '0;
        ifid_pc_plus1 <= '0;
        ifid_valid    <= 1'b0;
      end
    end else begin
      pc <= pc_plus1;
      if (flush) begin
        ifid_instr    <= '0;
        ifid_pc_plus1 <= '0;
        ifid_valid    <= 1'b0;
      end else begin
        ifid_instr    <= imem_data;
        ifid_pc_plus1 <= pc_plus1;
        ifid_valid    <= 1'b1;
        if (fetch_count != '1) begin
          fetch_count <= fetch_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage against a small imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = '0;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_data(imem_data), .imem_addr(imem_addr),
    .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory image: two fixed words, elsewhere address XOR a constant
  always_comb begin
    if (imem_addr == 16'h0000)      imem_data = 16'h3045;
    else if (imem_addr == 16'h0001) imem_data = 16'h3085;
    else                            imem_data = imem_addr ^ 16'hA5C3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                          input logic [15:0] pc1, input logic valid, input logic [15:0] cnt);
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".instr"}, ifid_instr, instr);
    check({tag, ".pc1"},   ifid_pc_plus1, pc1);
    check({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, valid});
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    step(); step();
    check_if("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    check("post_reset_addr", imem_addr, 16'h0000);

    // First two fetches
    step(); check_if("fetch0", 16'h0001, 16'h3045, 16'h0001, 1'b1, 16'd1);
    step(); check_if("fetch1", 16'h0002, 16'h3085, 16'h0002, 1'b1, 16'd2);

    // Stall held three cycles at PC=2
    stall = 1'b1;
    step(); check_if("stall1", 16'h0002, 16'h3085, 16'h0002, 1'b1, 16'd2);
    step(); check_if("stall2", 16'h0002, 16'h3085, 16'h0002, 1'b1, 16'd2);
    step(); check_if("stall3", 16'h0002, 16'h3085, 16'h0002, 1'b1, 16'd2);
    stall = 1'b0;
    step(); check_if("unstall", 16'h0003, 16'hA5C1, 16'h0003, 1'b1, 16'd3);

    // Flush alone, then flush with stall
    flush = 1'b1;
    step(); check_if("flush", 16'h0004, 16'h0000, 16'h0000, 1'b0, 16'd3);
    stall = 1'b1;
    step(); check_if("flush_stall", 16'h0004, 16'h0000, 16'h0000, 1'b0, 16'd3);
    flush = 1'b0; stall = 1'b0;
    step(); check_if("after_flush", 16'h0005, 16'hA5C7, 16'h0005, 1'b1, 16'd4);

    // Redirect beats stall
    redirect_valid = 1'b1; redirect_target = 16'h0008; stall = 1'b1;
    step(); check_if("redir_stall", 16'h0008, 16'h0000, 16'h0000, 1'b0, 16'd4);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check_if("redir_fetch", 16'h0009, 16'hA5CB, 16'h0009, 1'b1, 16'd5);

    // Redirect to current PC refetches it
    redirect_valid = 1'b1; redirect_target = 16'h0009;
    step(); check_if("redir_self", 16'h0009, 16'h0000, 16'h0000, 1'b0, 16'd5);
    redirect_valid = 1'b0;
    step(); check_if("refetch", 16'h000A, 16'hA5CA, 16'h000A, 1'b1, 16'd6);

    // PC wrap from FFFF
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    step(); check("wrap_addr_ffff", imem_addr, 16'hFFFF);
    redirect_valid = 1'b0;
    step(); check_if("wrap_fetch", 16'h0000, 16'h5A3C, 16'h0000, 1'b1, 16'd7);
    step(); check_if("wrap_next", 16'h0001, 16'h3045, 16'h0001, 1'b1, 16'd8);

    // Reset during redirect at PC=6
    for (int i = 0; i < 5; i++) step();
    check_if("pre_rst", 16'h0006, 16'hA5C6, 16'h0006, 1'b1, 16'd13);
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0020;
    step(); check_if("rst_redir", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    check("rst_release_valid", {15'd0, ifid_valid}, 16'h0000);
    step(); check_if("rst_refetch", 16'h0001, 16'h3045, 16'h0001, 1'b1, 16'd1);

    // Fetch counter saturation
    for (int i = 0; i < 65533; i++) step();
    check("count_fffe", fetch_count, 16'hFFFE);
    step(); check("count_ffff", fetch_count, 16'hFFFF);
    step(); check("count_sat", fetch_count, 16'hFFFF);
    check("sat_valid", {15'd0, ifid_valid}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port stall  input  1  hold PC and IF/ID register (hazard stall from decode).
REQ-005 SHALL have port flush  input  1  replace IF/ID contents with a bubble.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump/JR taken; load redirect_target into PC.
REQ-007 SHALL have port redirect_target  input  16  word address of next instruction on redirect.
REQ-008 SHALL have port imem_data  input  16  instruction returned combinationally by instruction memory for imem_addr.
REQ-009 SHALL have port imem_addr  output  16  current PC, word-addressed, driven to instruction memory.
REQ-010 SHALL have port ifid_instr  output  16  registered instruction handed to decode.
REQ-011 SHALL have port ifid_pc_plus1  output  16  registered PC+1 of ifid_instr (JAL link / branch base).
REQ-012 SHALL have port ifid_valid  output  1  ifid_instr is a real fetched instruction, not a bubble.
REQ-013 SHALL have port fetch_count  output  16  saturating count of valid instructions latched into IF/ID.

Function
REQ-014 SHALL hold PC in a 16-bit register and drive imem_addr = PC combinationally, with no added latency.
REQ-015 SHALL increment PC by 1 per cycle (word addressing); PC = 16'hFFFF SHALL wrap to 16'h0000.
REQ-016 SHALL evaluate per-cycle update priority as: rst > redirect_valid > stall > normal advance.
REQ-017 Normal advance (no rst, redirect, stall or flush): PC <= PC+1; ifid_instr <= imem_data; ifid_pc_plus1 <= PC+1; ifid_valid <= 1.
REQ-018 redirect_valid=1 SHALL load PC <= redirect_target and SHALL load the IF/ID bubble, regardless of stall or flush.
REQ-019 IF/ID bubble SHALL be ifid_instr=16'h0000 (NOP), ifid_pc_plus1=16'h0000, ifid_valid=0.
REQ-020 stall=1 without redirect SHALL hold PC and all IF/ID fields unchanged.
REQ-021 flush=1 without redirect or stall SHALL advance PC by 1 and load the IF/ID bubble.
REQ-022 flush=1 with stall=1 and no redirect SHALL hold PC and load the IF/ID bubble.
REQ-023 redirect_target equal to current PC SHALL be legal and refetch that address the following cycle.
REQ-024 fetch_count SHALL increment by 1 on each edge where ifid_valid is written 1, and SHALL saturate at 16'hFFFF.
REQ-025 Combinational paths from imem_data to any output other than through the IF/ID register SHALL NOT exist.
REQ-026 Outputs SHALL be free of X after the first reset edge for any imem_data value.

Reset
REQ-027 On rst: PC <= RESET_PC; ifid_instr <= 16'h0000; ifid_pc_plus1 <= 16'h0000; ifid_valid <= 0; fetch_count <= 0.
REQ-028 rst SHALL override stall, flush and redirect in the same cycle.
REQ-029 rst asserted mid-stream SHALL discard the in-flight IF/ID instruction, with no valid output on the cycle after reset release until one fetch completes.
REQ-030 First cycle after rst deasserts: imem_addr = RESET_PC; the first valid ifid_instr appears one edge later.

Verification
REQ-031 Reset, then imem returns 3045 @0, 3085 @1 -> ifid_instr 3045/pc_plus1 1/valid 1, next edge 3085/2/1; fetch_count 1 then 2.
REQ-032 At PC=5, redirect_valid=1, target=8, stall=1 -> next edge PC=8, ifid_valid=0, ifid_instr=0000; following edge ifid_instr = word @8, pc_plus1 9.
REQ-033 stall held 3 cycles at PC=2 -> imem_addr stays 2, IF/ID and fetch_count unchanged; release -> PC 3.
REQ-034 flush alone at PC=3 -> PC 4, ifid_valid 0; flush+stall at PC=4 -> PC 4, ifid_valid 0, fetch_count unchanged.
REQ-035 Redirect to FFFF, two normal cycles -> imem_addr FFFF then 0000, ifid_pc_plus1 0000 for the FFFF fetch.
REQ-036 rst during redirect at PC=6 -> PC=RESET_PC, IF/ID bubble, fetch_count 0; preload fetch_count to FFFE via 2 further fetches -> saturates at FFFF.
